// File: rtl/systolic_array_nxn.sv
// Output-stationary N x N signed MAC array with internal input skew, drain phase
// and row-by-row result readout with optional ReLU.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; accumulators hold the last job
// S_LOAD   | accepting k_len beats, one array step per accepted beat
// S_DRAIN  | 2N-2 steps with zeros injected so the skewed wavefront completes
// S_OUTPUT | presenting rows 0..N-1, each held until out_ready
module systolic_array_nxn #(
   parameter int WIDTH     = 8,
   parameter int N         = 4,
   parameter int ACC_WIDTH = 24,
   parameter int K_WIDTH   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [K_WIDTH-1:0]       k_len,
   input  logic                     activation,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N*WIDTH-1:0]       a_vec,
   input  logic [N*WIDTH-1:0]       b_vec,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(N)-1:0]     out_row,
   output logic [N*ACC_WIDTH-1:0]   out_data,
   output logic                     busy,
   output logic                     done
);

   localparam int ROW_W = $clog2(N);
   localparam int CNT_W = (K_WIDTH > 6) ? K_WIDTH : 6;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUTPUT} state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic                   act_q;
   logic [ROW_W-1:0]       row_q;
   logic                   done_q;
   logic                   step, clear;

   logic signed [WIDTH-1:0]     a_lane [N];
   logic signed [WIDTH-1:0]     b_lane [N];
   logic signed [WIDTH-1:0]     a_skew [N];
   logic signed [WIDTH-1:0]     b_skew [N];
   logic signed [WIDTH-1:0]     a_sk   [1:N-1][0:N-2];
   logic signed [WIDTH-1:0]     b_sk   [1:N-1][0:N-2];
   logic signed [WIDTH-1:0]     a_in   [N][N];
   logic signed [WIDTH-1:0]     b_in   [N][N];
   logic signed [WIDTH-1:0]     a_pipe [N][N-1];
   logic signed [WIDTH-1:0]     b_pipe [N-1][N];
   logic signed [2*WIDTH-1:0]   prod   [N][N];
   logic signed [ACC_WIDTH-1:0] acc    [N][N];
   logic signed [ACC_WIDTH-1:0] lane_v;

   always_comb begin
      state_nxt = state;
      step      = 1'b0;
      clear     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               clear     = 1'b1;
               state_nxt = (k_len == '0) ? S_OUTPUT : S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               step = 1'b1;
               if (cnt == CNT_W'(1)) state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            step = 1'b1;
            if (cnt == CNT_W'(1)) state_nxt = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (out_ready && row_q == ROW_W'(N-1)) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // cnt counts beats in LOAD, then is reloaded with the drain length
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         act_q  <= 1'b0;
         row_q  <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == S_OUTPUT) && (state_nxt == S_IDLE);
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt   <= CNT_W'(k_len);
                  act_q <= activation;
                  row_q <= '0;
               end
            end
            S_LOAD: begin
               if (in_valid) cnt <= (cnt == CNT_W'(1)) ? CNT_W'(2*N-2) : cnt - CNT_W'(1);
            end
            S_DRAIN: cnt <= cnt - CNT_W'(1);
            S_OUTPUT: begin
               if (out_ready) row_q <= (row_q == ROW_W'(N-1)) ? '0 : row_q + ROW_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_lane[i] = (state == S_LOAD) ? a_vec[i*WIDTH +: WIDTH] : '0;
         b_lane[i] = (state == S_LOAD) ? b_vec[i*WIDTH +: WIDTH] : '0;
      end
      a_skew[0] = a_lane[0];
      b_skew[0] = b_lane[0];
      for (int i = 1; i < N; i++) begin
         a_skew[i] = a_sk[i][i-1];
         b_skew[i] = b_sk[i][i-1];
      end
      for (int i = 0; i < N; i++) begin
         a_in[i][0] = a_skew[i];
         b_in[0][i] = b_skew[i];
         for (int j = 1; j < N; j++) begin
            a_in[i][j] = a_pipe[i][j-1];
            b_in[j][i] = b_pipe[j-1][i];
         end
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            prod[i][j] = a_in[i][j] * b_in[i][j];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || clear) begin
         for (int i = 1; i < N; i++)
            for (int d = 0; d < N-1; d++) begin
               a_sk[i][d] <= '0;
               b_sk[i][d] <= '0;
            end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N-1; j++) begin
               a_pipe[i][j] <= '0;
               b_pipe[j][i] <= '0;
            end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               acc[i][j] <= '0;
      end else if (step) begin
         // lane i enters a delay line of depth i so row i / column i lag by i steps
         for (int i = 1; i < N; i++) begin
            a_sk[i][0] <= a_lane[i];
            b_sk[i][0] <= b_lane[i];
            for (int d = 1; d < N-1; d++) begin
               if (d < i) begin
                  a_sk[i][d] <= a_sk[i][d-1];
                  b_sk[i][d] <= b_sk[i][d-1];
               end
            end
         end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N-1; j++) begin
               a_pipe[i][j] <= a_in[i][j];
               b_pipe[j][i] <= b_in[j][i];
            end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               acc[i][j] <= acc[i][j] + ACC_WIDTH'(prod[i][j]);
      end
   end

   always_comb begin
      out_data = '0;
      lane_v   = '0;
      if (state == S_OUTPUT) begin
         for (int j = 0; j < N; j++) begin
            lane_v = acc[row_q][j];
            if (act_q && lane_v[ACC_WIDTH-1]) lane_v = '0;
            out_data[j*ACC_WIDTH +: ACC_WIDTH] = lane_v;
         end
      end
   end

   assign in_ready  = (state == S_LOAD);
   assign out_valid = (state == S_OUTPUT);
   assign out_row   = row_q;
   assign busy      = (state != S_IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Randomized bench for systolic_array_nxn: matrix-product reference model,
// per-cycle output checker and a few hand-computed anchor values.
module tb_systolic_array_nxn;

   localparam int W    = 8;
   localparam int N    = 4;
   localparam int AW   = 16;
   localparam int KW   = 8;
   localparam int MAXK = 16;

   logic              clk = 1'b0;
   logic              rst_n, start, activation, in_valid, out_ready;
   logic [KW-1:0]     k_len;
   logic [N*W-1:0]    a_vec, b_vec;
   logic              in_ready, out_valid, busy, done;
   logic [1:0]        out_row;
   logic [N*AW-1:0]   out_data;

   always #5 clk = ~clk;

   systolic_array_nxn #(.WIDTH(W), .N(N), .ACC_WIDTH(AW), .K_WIDTH(KW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .activation(activation),
      .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_data(out_data), .busy(busy), .done(done)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int A [N][MAXK];
   int B [MAXK][N];
   logic [AW-1:0]   expd [N][N];
   logic [N*AW-1:0] exp_row_data [N];
   bit  chk_en   = 1'b0;
   int  exp_row  = 0;
   bit  exp_done = 1'b0;

   function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endfunction

   // C = A*B over the first k beats, wrapped to AW bits, optional ReLU
   function automatic void model(input int k, input bit act);
      for (int i = 0; i < N; i++) begin
         exp_row_data[i] = '0;
         for (int j = 0; j < N; j++) begin
            longint s;
            logic signed [AW-1:0] v;
            s = 0;
            for (int kk = 0; kk < k; kk++) s += longint'(A[i][kk]) * longint'(B[kk][j]);
            v = s[AW-1:0];
            if (act && v < 0) v = '0;
            expd[i][j] = v;
            exp_row_data[i][j*AW +: AW] = v;
         end
      end
   endfunction

   function automatic void clear_ops();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < MAXK; k++) begin
            A[i][k] = 0;
            B[k][i] = 0;
         end
   endfunction

   function automatic void rand_ops();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < MAXK; k++) begin
            A[i][k] = int'($urandom_range(0, 255)) - 128;
            B[k][i] = int'($urandom_range(0, 255)) - 128;
         end
   endfunction

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         chk("done", done, exp_done);
         exp_done = 1'b0;
         if (out_valid) begin
            chk("out_row", out_row, exp_row);
            chk("out_data", out_data, exp_row_data[exp_row]);
            if (out_ready) begin
               if (exp_row == N-1) exp_done = 1'b1;
               exp_row = (exp_row + 1) % N;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input int k, input bit act, input bit gap, input int stall, input bit poke_start);
      int idx, budget, lat, rows, hold;
      bit take;
      model(k, act);
      start = 1'b1; k_len = KW'(k); activation = act;
      tick();
      start = 1'b0; k_len = KW'($urandom); activation = ~act;
      chk("busy_after_start", busy, 1);
      idx = 0; budget = 0;
      while (idx < k && budget < 200) begin
         in_valid = gap ? ((budget % 2) == 0) : 1'b1;
         for (int i = 0; i < N; i++) begin
            a_vec[i*W +: W] = A[i][idx][W-1:0];
            b_vec[i*W +: W] = B[idx][i][W-1:0];
         end
         take = in_valid && in_ready;
         tick();
         budget++;
         if (take) idx++;
      end
      in_valid = 1'b0; a_vec = N*W'($urandom); b_vec = N*W'($urandom);
      chk("beats_accepted", idx, k);
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk("first_valid_latency", lat, (k == 0) ? 0 : 2*N-2);
      rows = 0; hold = 0; budget = 0;
      while (rows < N && budget < 200) begin
         out_ready = (hold >= stall);
         start = poke_start && (rows == 1);
         take = out_valid && out_ready;
         tick();
         budget++;
         if (take) begin
            rows++;
            hold = 0;
         end else hold++;
      end
      out_ready = 1'b0; start = 1'b0;
      chk("rows_consumed", rows, N);
      chk("idle_after_done", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; start = 1'b0; activation = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      k_len = '0; a_vec = '0; b_vec = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out_row", out_row, 0);
      chk("rst_out_data", out_data, 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      chk_en = 1'b1;
      tick();

      // 2x2 product embedded in the top-left corner
      clear_ops();
      A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
      B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
      model(2, 1'b0);
      chk("pin_c00", expd[0][0], 19);
      chk("pin_c01", expd[0][1], 22);
      chk("pin_c10", expd[1][0], 43);
      chk("pin_c11", expd[1][1], 50);
      run_job(2, 1'b0, 1'b0, 0, 1'b0);

      // ReLU on/off with identity B
      clear_ops();
      A[0][0] = -1; A[1][1] = 2; B[0][0] = 1; B[1][1] = 1;
      model(2, 1'b1);
      chk("pin_relu_c00", expd[0][0], 0);
      chk("pin_relu_c11", expd[1][1], 2);
      run_job(2, 1'b1, 1'b0, 1, 1'b0);
      model(2, 1'b0);
      chk("pin_raw_c00", expd[0][0], 16'hFFFF);
      run_job(2, 1'b0, 1'b0, 0, 1'b0);

      // input bubbles every other cycle plus output backpressure
      rand_ops();
      run_job(4, 1'b0, 1'b1, 3, 1'b0);

      // empty job with a stray start during readout
      run_job(0, 1'($urandom), 1'b0, 0, 1'b1);

      // reset in the middle of LOAD, then a clean job
      rand_ops();
      start = 1'b1; k_len = KW'(4); activation = 1'b0;
      tick();
      start = 1'b0;
      in_valid = 1'b1; a_vec = N*W'($urandom); b_vec = N*W'($urandom);
      tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_out_data", out_data, 0);
      exp_row = 0; exp_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();
      run_job(4, 1'b0, 1'b0, 0, 1'b0);

      // accumulator wrap: 4 * (-128 * -128) = 65536 wraps to 0 in 16 bits
      for (int i = 0; i < N; i++)
         for (int k = 0; k < MAXK; k++) begin
            A[i][k] = -128;
            B[k][i] = -128;
         end
      model(4, 1'b0);
      chk("pin_wrap_c00", expd[0][0], 0);
      chk("pin_wrap_c23", expd[2][3], 0);
      run_job(4, 1'b0, 1'b0, 0, 1'b0);

      for (int t = 0; t < 20; t++) begin
         rand_ops();
         run_job(int'($urandom_range(1, MAXK)), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)), 1'($urandom));
      end

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
